// File: rtl/run_supervisor.sv
// Run controller for the MIPS_R2000 core: sequences core reset, counts RUN cycles and
// ends the run on halt instruction, hung PC or cycle budget. Optional macro: RUN_SUPERVISOR_PERF_CNT_EN.
module run_supervisor #(
  parameter int          CNT_W       = 32,
  parameter int          MAX_CYCLES  = 2048,
  parameter int          RST_HOLD    = 4,
  parameter int          STALL_LIMIT = 16,
  parameter logic [31:0] HALT_INSTR  = 32'h0000_000C,
  parameter logic [31:0] HALT_MASK   = 32'hFC00_003F
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
`ifdef RUN_SUPERVISOR_PERF_CNT_EN
  input  logic             retire_in,
  output logic [CNT_W-1:0] instr_cnt,
`endif
  output logic             cpu_rst,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             halted,
  output logic             hung,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int SW = $clog2(STALL_LIMIT);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 2);
  localparam logic [SW-1:0]    STALL_ONE  = SW'(1);
  localparam logic [HW-1:0]    HOLD_ONE   = HW'(1);
  localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_r;
  logic [HW-1:0]    hold_cnt_r;
  logic [SW-1:0]    stall_cnt_r;
  logic [31:0]      pc_prev_r;
  logic             pc_valid_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic             cpu_rst_r;
  logic             done_r;
  logic             halted_r;
  logic             hung_r;
  logic             timeout_r;

  logic             pc_same_s;
  logic             halt_s;
  logic             stall_s;
  logic             budget_s;

  // Termination conditions evaluated on the current RUN-cycle inputs
  always_comb begin
    pc_same_s = pc_valid_r && (pc_in == pc_prev_r);
    halt_s    = ((instr_in & HALT_MASK) == (HALT_INSTR & HALT_MASK));
    stall_s   = pc_same_s && (stall_cnt_r == STALL_LAST);
    budget_s  = (cycle_cnt_r == CYC_LAST);
  end

  // Supervisor state machine with registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_HOLD;
      hold_cnt_r  <= '0;
      stall_cnt_r <= '0;
      pc_prev_r   <= 32'h0000_0000;
      pc_valid_r  <= 1'b0;
      cycle_cnt_r <= '0;
      cpu_rst_r   <= 1'b1;
      done_r      <= 1'b0;
      halted_r    <= 1'b0;
      hung_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r   <= ST_RUN;
            cpu_rst_r <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_ONE;
          end
        end
        ST_RUN: begin
          pc_prev_r   <= pc_in;
          pc_valid_r  <= 1'b1;
          stall_cnt_r <= pc_same_s ? (stall_cnt_r + STALL_ONE) : '0;
          // The terminating cycle is counted too, so cycle_cnt tops out at MAX_CYCLES
          cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
          if (halt_s || stall_s || budget_s) begin
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
            halted_r  <= halt_s;
            hung_r    <= !halt_s && stall_s;
            timeout_r <= !halt_s && !stall_s && budget_s;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r    <= ST_HOLD;
          hold_cnt_r <= '0;
          cpu_rst_r  <= 1'b1;
        end
      endcase
    end
  end

  assign state     = state_r;
  assign cpu_rst   = cpu_rst_r;
  assign cycle_cnt = cycle_cnt_r;
  assign done      = done_r;
  assign halted    = halted_r;
  assign hung      = hung_r;
  assign timeout   = timeout_r;

`ifdef RUN_SUPERVISOR_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_r;

  // Retired-instruction counter, live only in RUN and saturating at all-ones
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_cnt_r <= '0;
    end else if ((state_r == ST_RUN) && retire_in && !(&instr_cnt_r)) begin
      instr_cnt_r <= instr_cnt_r + CNT_ONE;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_run_supervisor.sv
// Self-checking bench for run_supervisor: a per-cycle vector table for reset/hold/halt,
// plus directed sequences for hang, timeout, priority and reset corner cases.
module tb_run_supervisor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        cpu_rst;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;
  logic        done;
  logic        halted;
  logic        hung;
  logic        timeout;
`ifdef RUN_SUPERVISOR_PERF_CNT_EN
  logic        retire_in;
  logic [31:0] instr_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  run_supervisor #(
    .CNT_W      (32),
    .MAX_CYCLES (64),
    .RST_HOLD   (4),
    .STALL_LIMIT(16),
    .HALT_INSTR (32'h0000_000C),
    .HALT_MASK  (32'hFC00_003F)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .pc_in    (pc_in),
    .instr_in (instr_in),
`ifdef RUN_SUPERVISOR_PERF_CNT_EN
    .retire_in(retire_in),
    .instr_cnt(instr_cnt),
`endif
    .cpu_rst  (cpu_rst),
    .state    (state),
    .cycle_cnt(cycle_cnt),
    .done     (done),
    .halted   (halted),
    .hung     (hung),
    .timeout  (timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [38:0] exp;
  } vec_t;

  vec_t vt[19];

  function automatic logic [38:0] pack(input logic cr, input logic [1:0] st, input logic d,
                                       input logic h, input logic hu, input logic to,
                                       input logic [31:0] cnt);
    return {cr, st, d, h, hu, to, cnt};
  endfunction

  function automatic logic [38:0] obs();
    return {cpu_rst, state, done, halted, hung, timeout, cycle_cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [38:0] exp);
    chk(name, {25'd0, obs()}, {25'd0, exp});
  endtask

  task automatic tick(input logic rst, input logic [31:0] pc, input logic [31:0] ins);
    RST      = rst;
    pc_in    = pc;
    instr_in = ins;
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_and_hold();
    tick(1'b1, 32'h0, 32'h0);
    tick(1'b1, 32'h0, 32'h0);
    repeat (4) tick(1'b0, 32'h0, 32'h0);
    chk_all("enter_run", pack(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int early;
    int bad;
    RST      = 1'b1;
    pc_in    = 32'h0;
    instr_in = 32'h0;
`ifdef RUN_SUPERVISOR_PERF_CNT_EN
    retire_in = 1'b0;
`endif

    // Vector table: two reset cycles, four hold cycles, RUN with halt on cycle 10
    for (int i = 0; i < 2; i++) vt[i] = '{1'b1, 32'h0, 32'h0, pack(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0)};
    for (int i = 2; i < 5; i++) vt[i] = '{1'b0, 32'h0, 32'h0, pack(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0)};
    vt[5] = '{1'b0, 32'h0, 32'h0, pack(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0)};
    for (int c = 0; c < 10; c++) begin
      vt[6+c].rst   = 1'b0;
      vt[6+c].pc    = 32'h0040_0000 + 32'(4 * c);
      vt[6+c].instr = (c == 4) ? 32'h0000_000D : ((c == 7) ? 32'h4000_000C : 32'h0);
      vt[6+c].exp   = pack(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'(c + 1));
    end
    vt[16] = '{1'b0, 32'h0040_0028, 32'h0000_000C, pack(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd11)};
    for (int i = 17; i < 19; i++) vt[i] = '{1'b0, 32'h0040_0028, 32'h0000_000C, pack(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd11)};

    for (int i = 0; i < 19; i++) begin
      tick(vt[i].rst, vt[i].pc, vt[i].instr);
      chk($sformatf("vec%0d", i), {25'd0, obs()}, {25'd0, vt[i].exp});
    end

    // Hang: PC stuck from RUN cycle 5 -> hung with cycle_cnt 21, then frozen
    reset_and_hold();
    early = 0;
    for (int c = 0; c < 21; c++) begin
      tick(1'b0, (c < 5) ? 32'h0040_0000 + 32'(4 * c) : 32'h0040_0020, 32'h0);
      if (c < 20 && done) early = 1;
    end
    chk("hung_not_early", 64'(early), 64'd0);
    chk_all("hung_final", pack(1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd21));
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1'b0, 32'h0000_1000 + 32'(4 * c), 32'h0000_000C);
      if (obs() !== pack(1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'd21)) bad++;
    end
    chk("hung_frozen", 64'(bad), 64'd0);

    // Timeout: PC always changing (wraps through zero), budget 64
    reset_and_hold();
    early = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1'b0, 32'hFFFF_FF80 + 32'(4 * c), 32'h0);
      if (c < 63 && done) early = 1;
    end
    chk("timeout_not_early", 64'(early), 64'd0);
    chk_all("timeout_final", pack(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd64));
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 32'h0000_2000 + 32'(4 * c), 32'h0);
      if (obs() !== pack(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd64)) bad++;
    end
    chk("timeout_frozen", 64'(bad), 64'd0);

    // Priority: halt, stall and budget all true on cycle 63
    reset_and_hold();
    early = 0;
    for (int c = 0; c < 64; c++) begin
      tick(1'b0, (c < 48) ? 32'h0000_1000 + 32'(4 * c) : 32'h0000_2000,
           (c == 63) ? 32'h0000_000C : 32'h0);
      if (c < 63 && done) early = 1;
    end
    chk("prio_not_early", 64'(early), 64'd0);
    chk_all("prio_final", pack(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd64));

    // Halt on the first RUN cycle, with don't-care instruction bits set
    reset_and_hold();
    tick(1'b0, 32'h0040_0000, 32'h03FF_FFCC);
    chk_all("first_cycle_halt", pack(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1));

    // Reset mid-RUN after a 15-cycle PC stall that must not count as a hang
    reset_and_hold();
    early = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, (c >= 2 && c <= 16) ? 32'h0000_5000 : 32'h0000_6000 + 32'(4 * c), 32'h0);
      if (done) early = 1;
    end
    chk("stall_below_limit", 64'(early), 64'd0);
    chk_all("run_before_rst", pack(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd30));
    tick(1'b1, 32'h0, 32'h0);
    chk_all("rst_mid_run", pack(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));

    // Reset during HOLD restarts the hold count
    tick(1'b0, 32'h0, 32'h0);
    tick(1'b0, 32'h0, 32'h0);
    tick(1'b1, 32'h0, 32'h0);
    repeat (3) tick(1'b0, 32'h0, 32'h0);
    chk_all("hold_restart_3", pack(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
    tick(1'b0, 32'h0, 32'h0);
    chk_all("hold_restart_4", pack(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));

    // Halt on cycle 2, then reset while in DONE
    tick(1'b0, 32'h0000_0100, 32'h0);
    tick(1'b0, 32'h0000_0104, 32'h0);
    tick(1'b0, 32'h0000_0108, 32'h0000_000C);
    chk_all("halt_cycle2", pack(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3));
    tick(1'b1, 32'h0, 32'h0);
    chk_all("rst_in_done", pack(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));

`ifdef RUN_SUPERVISOR_PERF_CNT_EN
    chk("perf_reset", 64'(instr_cnt), 64'd0);
    reset_and_hold();
    for (int c = 0; c < 20; c++) begin
      retire_in = (c % 2 == 0);
      tick(1'b0, 32'h0000_3000 + 32'(4 * c), 32'h0);
    end
    chk("perf_20", 64'(instr_cnt), 64'd10);
    retire_in = 1'b1;
    tick(1'b0, 32'h0000_4000, 32'h0000_000C);
    chk("perf_term", 64'(instr_cnt), 64'd11);
    tick(1'b0, 32'h0000_4004, 32'h0);
    tick(1'b0, 32'h0000_4008, 32'h0);
    chk("perf_frozen", 64'(instr_cnt), 64'd11);
    retire_in = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
